// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-fill and main-memory signal bundle around the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_grant;
    logic              i_data_valid;
    logic [ADDR_W-1:0] i_word_addr;
    logic              i_done;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_grant;
    logic              d_data_valid;
    logic [ADDR_W-1:0] d_word_addr;
    logic              d_done;

    logic [DATA_W-1:0] rd_data;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_data;
    logic              mem_data_valid;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data, mem_data_valid,
        output i_grant, i_data_valid, i_word_addr, i_done,
        output d_grant, d_data_valid, d_word_addr, d_done,
        output rd_data, mem_enable, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data, mem_data_valid,
        input  i_grant, i_data_valid, i_word_addr, i_done,
        input  d_grant, d_data_valid, d_word_addr, d_done,
        input  rd_data, mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin owner of pipelined main memory for I/D cache fills and D write-through
module mem_arbiter #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int OFS_W = $clog2(WORDS);
    localparam int CNT_W = OFS_W + 1;
    localparam int BLK_W = ADDR_W - OFS_W - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

    state_t           state, state_nxt;
    logic             owner_d, owner_d_nxt;
    logic             last_d, last_d_nxt;
    logic [BLK_W-1:0] blk, blk_nxt;
    logic [CNT_W-1:0] iss_cnt, iss_cnt_nxt;
    logic [CNT_W-1:0] ret_cnt, ret_cnt_nxt;
    logic             ret_valid, ret_last;
    logic             pick_d, pick_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            blk     <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            state   <= state_nxt;
            owner_d <= owner_d_nxt;
            last_d  <= last_d_nxt;
            blk     <= blk_nxt;
            iss_cnt <= iss_cnt_nxt;
            ret_cnt <= ret_cnt_nxt;
        end
    end

    assign bus.rd_data = bus.mem_data;

    // Returns are only meaningful while a fill owns memory; stray ones are dropped.
    assign ret_valid = bus.mem_data_valid && (state == ISSUE || state == DRAIN);
    assign ret_last  = ret_valid && (ret_cnt == CNT_W'(WORDS - 1));

    always_comb begin
        state_nxt        = state;
        owner_d_nxt      = owner_d;
        last_d_nxt       = last_d;
        blk_nxt          = blk;
        iss_cnt_nxt      = iss_cnt;
        ret_cnt_nxt      = ret_cnt;
        pick_d           = 1'b0;
        pick_i           = 1'b0;
        bus.mem_enable   = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = {DATA_W{1'b0}};
        bus.i_data_valid = 1'b0;
        bus.d_data_valid = 1'b0;
        bus.i_done       = 1'b0;
        bus.d_done       = 1'b0;
        bus.i_word_addr  = {blk, ret_cnt[OFS_W-1:0], 1'b0};
        bus.d_word_addr  = {blk, ret_cnt[OFS_W-1:0], 1'b0};
        bus.i_grant      = (state != IDLE) && !owner_d;
        bus.d_grant      = (state != IDLE) && owner_d;

        case (state)
            IDLE: begin
                // With both requesting, the side that did not win last time goes first.
                pick_d = bus.d_req && (!bus.i_req || !last_d);
                pick_i = bus.i_req && !pick_d;
                if (pick_d || pick_i) begin
                    owner_d_nxt = pick_d;
                    last_d_nxt  = pick_d;
                    blk_nxt     = pick_d ? bus.d_addr[ADDR_W-1:OFS_W+1]
                                         : bus.i_addr[ADDR_W-1:OFS_W+1];
                    iss_cnt_nxt = '0;
                    ret_cnt_nxt = '0;
                    state_nxt   = (pick_d && bus.d_wr) ? WRITE : ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_enable = 1'b1;
                bus.mem_addr   = {blk, iss_cnt[OFS_W-1:0], 1'b0};
                iss_cnt_nxt    = iss_cnt + CNT_W'(1);
                if (iss_cnt == CNT_W'(WORDS - 1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
            end
            WRITE: begin
                bus.mem_enable = 1'b1;
                bus.mem_wr     = 1'b1;
                bus.mem_addr   = bus.d_addr;
                bus.mem_wdata  = bus.d_wdata;
                bus.d_done     = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (ret_valid) begin
            bus.i_data_valid = !owner_d;
            bus.d_data_valid = owner_d;
            ret_cnt_nxt      = ret_cnt + CNT_W'(1);
            if (ret_last) begin
                bus.i_done = !owner_d;
                bus.d_done = owner_d;
                state_nxt  = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: owner 0 none, 1 I, 2 D
    int   m_owner = 0;
    bit   m_write = 0;
    int   m_blk = 0, m_iss = 0, m_ret = 0, m_last = 1;
    bit   started = 0;

    // memory model
    int          lat = 2;
    bit          pv [0:15];
    logic [15:0] pa [0:15];
    bit          nxt_v = 0;
    logic [15:0] nxt_d = '0;

    // observed events
    int          cyc = 0;
    int          n_iv, n_dv, n_idone, n_ddone, n_wr, n_drop;
    logic [15:0] wr_addr, wr_data;
    logic [15:0] iss_log[$];
    logic [15:0] wlog[$];
    int          grant_log[$];
    int          ev_id[$], ev_dd[$], ev_ig[$];
    bit          prev_ig = 0, prev_dg = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        n_iv = 0; n_dv = 0; n_idone = 0; n_ddone = 0; n_wr = 0; n_drop = 0;
        wr_addr = '0; wr_data = '0;
        iss_log.delete(); wlog.delete(); grant_log.delete();
        ev_id.delete(); ev_dd.delete(); ev_ig.delete();
    endtask

    function automatic bit sig(input int sel);
        case (sel)
            0: return bus.i_done === 1'b1;
            1: return bus.d_done === 1'b1;
            2: return bus.i_data_valid === 1'b1;
            3: return bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0;
            4: return bus.i_grant === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (sig(sel)) return;
            n++;
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL timeout %s: event not seen within %0d cycles", name, budget);
                return;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        bus.mem_data_valid = nxt_v;
        bus.mem_data       = nxt_d;
    end

    always @(negedge clk) begin
        bit          fill, e_ig, e_dg, e_en, e_valid, e_done, issue;
        logic [15:0] e_addr, e_waddr;
        int          pick;
        cyc++;
        if (started) begin
            fill    = (m_owner != 0) && !m_write;
            e_ig    = (m_owner == 1);
            e_dg    = (m_owner == 2);
            e_en    = m_write || (fill && m_iss < 8);
            e_valid = fill && bus.mem_data_valid;
            e_done  = e_valid && (m_ret == 7);
            e_addr  = m_write ? bus.d_addr : 16'(m_blk * 16 + 2 * m_iss);
            e_waddr = 16'(m_blk * 16 + 2 * m_ret);
            chk("i_grant", 32'(bus.i_grant), 32'(e_ig));
            chk("d_grant", 32'(bus.d_grant), 32'(e_dg));
            chk("mem_enable", 32'(bus.mem_enable), 32'(e_en));
            chk("mem_wr", 32'(bus.mem_wr), 32'(m_write));
            chk("i_data_valid", 32'(bus.i_data_valid), 32'(e_valid && e_ig));
            chk("d_data_valid", 32'(bus.d_data_valid), 32'(e_valid && e_dg));
            chk("i_done", 32'(bus.i_done), 32'(e_done && e_ig));
            chk("d_done", 32'(bus.d_done), 32'((e_done && e_dg) || m_write));
            if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            if (m_write) chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.d_wdata));
            if (e_valid && e_ig) chk("i_word_addr", 32'(bus.i_word_addr), 32'(e_waddr));
            if (e_valid && e_dg) chk("d_word_addr", 32'(bus.d_word_addr), 32'(e_waddr));
            if (e_valid) chk("rd_data", 32'(bus.rd_data), 32'(e_waddr ^ 16'h5A3C));

            if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0) iss_log.push_back(bus.mem_addr);
            if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b1) begin
                n_wr++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata;
            end
            if (bus.i_data_valid === 1'b1) begin n_iv++; wlog.push_back(bus.i_word_addr); end
            if (bus.d_data_valid === 1'b1) n_dv++;
            if (bus.i_done === 1'b1) begin n_idone++; ev_id.push_back(cyc); end
            if (bus.d_done === 1'b1) begin n_ddone++; ev_dd.push_back(cyc); end
            if (bus.i_grant === 1'b1 && !prev_ig) begin grant_log.push_back(1); ev_ig.push_back(cyc); end
            if (bus.d_grant === 1'b1 && !prev_dg) grant_log.push_back(2);
            if (bus.mem_data_valid && bus.i_data_valid !== 1'b1 && bus.d_data_valid !== 1'b1) n_drop++;
            prev_ig = (bus.i_grant === 1'b1);
            prev_dg = (bus.d_grant === 1'b1);
        end

        if (rst) begin
            m_owner = 0; m_write = 0; m_last = 1; m_iss = 0; m_ret = 0;
            started = 1;
        end else if (m_owner == 0) begin
            if (bus.i_req || bus.d_req) begin
                pick    = (bus.d_req && (!bus.i_req || m_last == 1)) ? 2 : 1;
                m_owner = pick;
                m_last  = pick;
                m_iss   = 0;
                m_ret   = 0;
                m_write = (pick == 2) && bus.d_wr;
                m_blk   = int'((pick == 2) ? bus.d_addr : bus.i_addr) / 16;
            end
        end else if (m_write) begin
            m_owner = 0;
            m_write = 0;
        end else begin
            if (bus.mem_data_valid) begin
                if (m_ret == 7) m_owner = 0;
                m_ret++;
            end
            if (m_iss < 8) m_iss++;
        end

        issue = (bus.mem_enable === 1'b1) && (bus.mem_wr === 1'b0);
        for (int k = 0; k < 15; k++) begin
            pv[k] = pv[k+1];
            pa[k] = pa[k+1];
        end
        pv[15] = 1'b0;
        pv[lat-1] = issue;
        pa[lat-1] = bus.mem_addr;
        nxt_v = pv[0];
        nxt_d = pv[0] ? (pa[0] ^ 16'h5A3C) : 16'h0000;
    end

    initial begin
        for (int k = 0; k < 16; k++) begin pv[k] = 1'b0; pa[k] = '0; end
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_data = '0; bus.mem_data_valid = 0;
        clear_obs();
        tick(3);
        rst = 0;
        @(negedge clk);
        chk("reset i_grant", 32'(bus.i_grant), 32'd0);
        chk("reset d_grant", 32'(bus.d_grant), 32'd0);
        chk("reset mem_enable", 32'(bus.mem_enable), 32'd0);
        tick(1);

        // 1: I fill alone
        clear_obs();
        bus.i_addr = 16'h1236; bus.i_req = 1;
        wait_for(0, 40, "t1 i_done");
        @(posedge clk); #1; bus.i_req = 0;
        @(negedge clk);
        chk("t1 grant dropped", 32'(bus.i_grant), 32'd0);
        tick(3);
        chk("t1 issues", iss_log.size(), 8);
        chk("t1 first addr", 32'(iss_log[0]), 32'h1230);
        chk("t1 last addr", 32'(iss_log[iss_log.size()-1]), 32'h123E);
        chk("t1 valids", n_iv, 8);
        chk("t1 last word addr", 32'(wlog[wlog.size()-1]), 32'h123E);
        chk("t1 dones", n_idone, 1);

        // 2: simultaneous fills, round robin D, I, D
        clear_obs();
        bus.i_addr = 16'h3010; bus.d_addr = 16'h2000; bus.d_wr = 0;
        bus.i_req = 1; bus.d_req = 1;
        wait_for(1, 40, "t2 d_done a");
        wait_for(0, 40, "t2 i_done");
        wait_for(1, 40, "t2 d_done b");
        @(posedge clk); #1; bus.i_req = 0; bus.d_req = 0;
        tick(4);
        chk("t2 grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("t2 first D", grant_log[0], 2);
            chk("t2 then I", grant_log[1], 1);
            chk("t2 then D", grant_log[2], 2);
        end
        if (ev_ig.size() > 0 && ev_dd.size() > 0)
            chk("t2 idle gap", ev_ig[0] - ev_dd[0], 2);

        // 3: D write-through
        clear_obs();
        bus.d_addr = 16'h4002; bus.d_wdata = 16'hBEEF; bus.d_wr = 1; bus.d_req = 1;
        wait_for(1, 20, "t3 d_done");
        @(posedge clk); #1; bus.d_req = 0; bus.d_wr = 0;
        tick(3);
        chk("t3 writes", n_wr, 1);
        chk("t3 wr addr", 32'(wr_addr), 32'h4002);
        chk("t3 wr data", 32'(wr_data), 32'hBEEF);
        chk("t3 d valids", n_dv, 0);
        chk("t3 dones", n_ddone, 1);

        // 4: write requested during an I fill
        clear_obs();
        bus.i_addr = 16'h5008; bus.i_req = 1;
        wait_for(4, 20, "t4 i_grant");
        tick(2);
        bus.d_addr = 16'h6004; bus.d_wdata = 16'h1234; bus.d_wr = 1; bus.d_req = 1;
        wait_for(0, 40, "t4 i_done");
        @(posedge clk); #1; bus.i_req = 0;
        wait_for(1, 20, "t4 d_done");
        @(posedge clk); #1; bus.d_req = 0; bus.d_wr = 0;
        tick(3);
        chk("t4 d valids", n_dv, 0);
        chk("t4 i valids", n_iv, 8);
        chk("t4 writes", n_wr, 1);
        chk("t4 wr addr", 32'(wr_addr), 32'h6004);
        if (ev_id.size() > 0 && ev_dd.size() > 0)
            chk("t4 write after fill", ev_dd[0] - ev_id[0], 2);

        // 6: I drops its request after the second issue
        clear_obs();
        bus.i_addr = 16'h7FF2; bus.i_req = 1;
        wait_for(3, 20, "t6 issue 1");
        wait_for(3, 20, "t6 issue 2");
        @(posedge clk); #1; bus.i_req = 0;
        wait_for(0, 40, "t6 i_done");
        tick(3);
        chk("t6 issues", iss_log.size(), 8);
        chk("t6 last addr", 32'(iss_log[iss_log.size()-1]), 32'h7FFE);
        chk("t6 valids", n_iv, 8);
        chk("t6 dones", n_idone, 1);

        // 5: reset while draining, long-latency memory
        lat = 10;
        clear_obs();
        bus.i_addr = 16'h0A40; bus.i_req = 1;
        wait_for(2, 40, "t5 return 1");
        wait_for(2, 10, "t5 return 2");
        @(posedge clk); #1; rst = 1; bus.i_req = 0;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("t5 grant after reset", 32'(bus.i_grant), 32'd0);
        tick(16);
        chk("t5 valids", n_iv, 3);
        chk("t5 dones", n_idone, 0);
        chk("t5 dropped returns", n_drop, 5);
        lat = 2;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
